// File: rtl/pu_or1k_rf_pkg.sv
// Shared types and constants for the multi-context OR1K register file.
package pu_or1k_rf_pkg;

   // Background clear engine states
   typedef enum logic [1:0] {
      RF_CLR_IDLE  = 2'd0,
      RF_CLR_CLEAR = 2'd1,
      RF_CLR_DONE  = 2'd2
   } rf_clr_state_e;

   // SPR group 0, GPR window starts at 0x400 (address bits [15:9] == 2)
   localparam logic [6:0] RF_SPR_GROUP = 7'h2;

   // Width of a context index; a single context still needs one bit
   function automatic int rf_ctx_width(input int num_ctx);
      int w;
      if (num_ctx <= 1) begin
         w = 1;
      end else begin
         w = $clog2(num_ctx);
      end
      return w;
   endfunction

endpackage

// File: rtl/pu_or1k_rf_read_port.sv
// One registered read port: capture on rd_en, same-cycle write bypass,
// and refresh of the held word when the pipeline writes it later.
module pu_or1k_rf_read_port #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_adr,
   input  logic [CW-1:0] cur_ctx,
   input  logic [DW-1:0] mem_dat,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_adr,
   input  logic [DW-1:0] wr_dat,
   output logic [DW-1:0] rd_dat
);

   logic [AW-1:0] hold_adr_r;
   logic [CW-1:0] hold_ctx_r;
   logic [DW-1:0] dat_r;
   logic          hit_new_s;
   logic          hit_hold_s;

   // Match the pipeline write against the new and the held address
   always_comb begin
      hit_new_s  = wr_en && (wr_adr == rd_adr);
      hit_hold_s = wr_en && (wr_adr == hold_adr_r) && (cur_ctx == hold_ctx_r);
   end

   // Output register: capture with bypass, otherwise hold and track writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_adr_r <= '0;
         hold_ctx_r <= '0;
         dat_r      <= '0;
      end else if (rd_en) begin
         hold_adr_r <= rd_adr;
         hold_ctx_r <= cur_ctx;
         dat_r      <= hit_new_s ? wr_dat : mem_dat;
      end else if (hit_hold_s) begin
         dat_r      <= wr_dat;
      end
   end

   assign rd_dat = dat_r;

endmodule

// File: rtl/pu_or1k_rf_multictx.sv
// Multi-context OR1K general-purpose register file with SPR access and a
// background bank-clear engine.
// Optional: define PU_OR1K_RF_R0_ZERO_EN to hard-wire r0 of every context to 0.
module pu_or1k_rf_multictx
   import pu_or1k_rf_pkg::*;
#(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int OPTION_RF_ADDR_WIDTH = 5,
   parameter int RF_WORDS             = 32,
   parameter int NUM_CONTEXTS         = 4,
   parameter int NUM_READ_PORTS       = 2,
   localparam int CW = rf_ctx_width(NUM_CONTEXTS)
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [NUM_READ_PORTS-1:0]                      rd_en_i,
   input  logic [NUM_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0] rd_adr_i,
   output logic [NUM_READ_PORTS*OPTION_OPERAND_WIDTH-1:0] rd_dat_o,
   input  logic                                           wr_en_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0]                wr_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]                wr_dat_i,
   input  logic                                           ctx_switch_i,
   input  logic [CW-1:0]                                  ctx_sel_i,
   output logic [CW-1:0]                                  active_ctx_o,
   input  logic                                           clear_req_i,
   input  logic [CW-1:0]                                  clear_ctx_i,
   output logic                                           clear_err_o,
   output logic                                           busy_o,
   input  logic [15:0]                                    spr_bus_addr_i,
   input  logic                                           spr_bus_stb_i,
   input  logic                                           spr_bus_we_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]                spr_bus_dat_i,
   output logic                                           spr_gpr_ack_o,
   output logic [OPTION_OPERAND_WIDTH-1:0]                spr_gpr_dat_o
);

   localparam int DW = OPTION_OPERAND_WIDTH;
   localparam int AW = OPTION_RF_ADDR_WIDTH;
   localparam logic [AW-1:0] CNT_ONE = AW'(1);
`ifdef PU_OR1K_RF_R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   // A word index is backed by storage (in range, and not a hard-wired r0)
   function automatic logic word_ok(input logic [AW-1:0] a);
      return (int'(a) < RF_WORDS) && !(R0_ZERO && (a == '0));
   endfunction

   logic [DW-1:0] mem_r [NUM_CONTEXTS][RF_WORDS];
   logic [CW-1:0] active_ctx_r;
   rf_clr_state_e clr_state_r, clr_state_s;
   logic [AW-1:0] clr_cnt_r;
   logic [CW-1:0] clr_ctx_r;
   logic          busy_r, clear_err_r, spr_rd_ack_r;
   logic [DW-1:0] spr_dat_r;

   logic          pipe_we_s, clr_we_s, clr_start_s, clr_reject_s, clear_err_s;
   logic          spr_hit_s, spr_loc_ok_s, spr_wr_go_s, spr_we_s;
   logic [AW-1:0] spr_adr_s;
   logic [CW-1:0] spr_ctx_s;
   logic [DW-1:0] spr_rd_dat_s;
   logic [DW-1:0] rd_mem_s [NUM_READ_PORTS];
   logic          spr_addr_unused_s;

   assign spr_addr_unused_s = ^spr_bus_addr_i[8:AW+CW];

   // Decode pipeline write and SPR bus request
   always_comb begin
      pipe_we_s    = wr_en_i && word_ok(wr_adr_i);
      spr_hit_s    = spr_bus_stb_i && (spr_bus_addr_i[15:9] == RF_SPR_GROUP);
      spr_adr_s    = spr_bus_addr_i[AW-1:0];
      spr_ctx_s    = spr_bus_addr_i[AW+CW-1:AW];
      spr_loc_ok_s = word_ok(spr_adr_s) && (int'(spr_ctx_s) < NUM_CONTEXTS);
      spr_wr_go_s  = spr_hit_s && spr_bus_we_i && !wr_en_i && (clr_state_r != RF_CLR_CLEAR);
      spr_we_s     = spr_wr_go_s && spr_loc_ok_s;
      spr_rd_dat_s = spr_loc_ok_s ? mem_r[spr_ctx_s][spr_adr_s] : '0;
   end

   // Storage: pipeline beats clear, clear beats SPR on the same word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CONTEXTS; c++)
            for (int w = 0; w < RF_WORDS; w++)
               mem_r[c][w] <= '0;
      end else begin
         for (int c = 0; c < NUM_CONTEXTS; c++) begin
            for (int w = 0; w < RF_WORDS; w++) begin
               if (pipe_we_s && (c == int'(active_ctx_r)) && (w == int'(wr_adr_i)))
                  mem_r[c][w] <= wr_dat_i;
               else if (clr_we_s && (c == int'(clr_ctx_r)) && (w == int'(clr_cnt_r)))
                  mem_r[c][w] <= '0;
               else if (spr_we_s && (c == int'(spr_ctx_s)) && (w == int'(spr_adr_s)))
                  mem_r[c][w] <= spr_bus_dat_i;
            end
         end
      end
   end

   // Active context register; switch takes effect after the request cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_ctx_r <= '0;
      end else if (ctx_switch_i && (NUM_CONTEXTS > 1)) begin
         active_ctx_r <= ctx_sel_i;
      end
   end

   assign active_ctx_o = active_ctx_r;

   // Array read for each port from the active context
   always_comb begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         rd_mem_s[p] = '0;
         if (word_ok(rd_adr_i[p*AW +: AW])) begin
            rd_mem_s[p] = mem_r[active_ctx_r][rd_adr_i[p*AW +: AW]];
         end else begin
            rd_mem_s[p] = '0;
         end
      end
   end

   for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd
      pu_or1k_rf_read_port #(.DW(DW), .AW(AW), .CW(CW)) u_rd_port (
         .clk     (clk),
         .rst     (rst),
         .rd_en   (rd_en_i[g]),
         .rd_adr  (rd_adr_i[g*AW +: AW]),
         .cur_ctx (active_ctx_r),
         .mem_dat (rd_mem_s[g]),
         .wr_en   (pipe_we_s),
         .wr_adr  (wr_adr_i),
         .wr_dat  (wr_dat_i),
         .rd_dat  (rd_dat_o[g*DW +: DW])
      );
   end

   // Clear FSM state register, word counter and latched bank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_state_r <= RF_CLR_IDLE;
         clr_cnt_r   <= '0;
         clr_ctx_r   <= '0;
      end else begin
         clr_state_r <= clr_state_s;
         if (clr_start_s) begin
            clr_ctx_r <= clear_ctx_i;
            clr_cnt_r <= '0;
         end else if (clr_state_r == RF_CLR_CLEAR) begin
            clr_cnt_r <= clr_cnt_r + CNT_ONE;
         end
      end
   end

   // Clear FSM next state; the active bank (or the one being switched to) is refused
   always_comb begin
      clr_reject_s = (NUM_CONTEXTS == 1) || (clear_ctx_i == active_ctx_r) ||
                     (ctx_switch_i && (clear_ctx_i == ctx_sel_i));
      clr_state_s  = clr_state_r;
      case (clr_state_r)
         RF_CLR_IDLE: begin
            if (clear_req_i && !clr_reject_s) clr_state_s = RF_CLR_CLEAR;
            else                              clr_state_s = RF_CLR_IDLE;
         end
         RF_CLR_CLEAR: begin
            if (int'(clr_cnt_r) == RF_WORDS - 1) clr_state_s = RF_CLR_DONE;
            else                                 clr_state_s = RF_CLR_CLEAR;
         end
         RF_CLR_DONE: clr_state_s = RF_CLR_IDLE;
         default:     clr_state_s = RF_CLR_IDLE;
      endcase
   end

   // Clear FSM outputs: start strobe, word write, request rejection
   always_comb begin
      clr_start_s = 1'b0;
      clr_we_s    = 1'b0;
      clear_err_s = 1'b0;
      case (clr_state_r)
         RF_CLR_IDLE: begin
            clr_start_s = clear_req_i && !clr_reject_s;
            clear_err_s = clear_req_i && clr_reject_s;
         end
         RF_CLR_CLEAR: begin
            clr_we_s    = word_ok(clr_cnt_r);
            clear_err_s = clear_req_i;
         end
         RF_CLR_DONE: begin
            clear_err_s = clear_req_i;
         end
         default: begin
            clear_err_s = 1'b0;
         end
      endcase
   end

   // Registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r      <= 1'b0;
         clear_err_r <= 1'b0;
      end else begin
         busy_r      <= (clr_state_s == RF_CLR_CLEAR);
         clear_err_r <= clear_err_s;
      end
   end

   assign busy_o      = busy_r;
   assign clear_err_o = clear_err_r;

   // SPR read: sample data on the first strobe cycle, ack while strobe stays high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spr_rd_ack_r <= 1'b0;
         spr_dat_r    <= '0;
      end else begin
         spr_rd_ack_r <= spr_hit_s && !spr_bus_we_i;
         if (spr_hit_s && !spr_bus_we_i && !spr_rd_ack_r) begin
            spr_dat_r <= spr_rd_dat_s;
         end
      end
   end

   assign spr_gpr_ack_o = spr_rd_ack_r | spr_wr_go_s;
   assign spr_gpr_dat_o = spr_dat_r;

endmodule
